// File: rtl/csr_file_if.sv
// csr_file_if: CSR access, exception/return commit and interrupt lines between the pipeline and the CSR file.
interface csr_file_if;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] coreid_in;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;

    modport master (
        output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
               wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
               hw_int_in, ipi_int_in, coreid_in,
        input  csr_rvalue, has_int, ex_entry, ertn_entry
    );
    modport slave (
        input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
               wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
               hw_int_in, ipi_int_in, coreid_in,
        output csr_rvalue, has_int, ex_entry, ertn_entry
    );
endinterface

// File: rtl/csr_file.sv
// csr_file: control/status registers with masked writes, exception entry/return state and a countdown timer interrupt.
module csr_file #(
    parameter int TIMER_W = 32
) (
    input  logic      clk,
    input  logic      resetn,
    csr_file_if.slave bus
);
    localparam logic [13:0] A_CRMD   = 14'h00;
    localparam logic [13:0] A_PRMD   = 14'h01;
    localparam logic [13:0] A_ECFG   = 14'h04;
    localparam logic [13:0] A_ESTAT  = 14'h05;
    localparam logic [13:0] A_ERA    = 14'h06;
    localparam logic [13:0] A_BADV   = 14'h07;
    localparam logic [13:0] A_EENTRY = 14'h0c;
    localparam logic [13:0] A_SAVE0  = 14'h30;
    localparam logic [13:0] A_SAVE1  = 14'h31;
    localparam logic [13:0] A_SAVE2  = 14'h32;
    localparam logic [13:0] A_SAVE3  = 14'h33;
    localparam logic [13:0] A_TID    = 14'h40;
    localparam logic [13:0] A_TCFG   = 14'h41;
    localparam logic [13:0] A_TVAL   = 14'h42;

    logic [8:0]         r_crmd;
    logic [2:0]         r_prmd;
    logic [12:0]        r_ecfg;
    logic [12:0]        r_is;
    logic [5:0]         r_ecode;
    logic [8:0]         r_esub;
    logic [31:0]        r_era;
    logic [31:0]        r_badv;
    logic [25:0]        r_eentry;
    logic [31:0]        r_save [4];
    logic [31:0]        r_tid;
    logic [31:0]        r_tcfg;
    logic [TIMER_W-1:0] r_tval;

    logic               w_wr;
    logic [31:0]        w_set;
    logic [31:0]        w_keep;
    logic [8:0]         w_crmd_wr;
    logic [8:0]         w_crmd_nx;
    logic               w_tcfg_we;
    logic [31:0]        w_tcfg_nx;
    logic               w_expire;
    logic               w_ticlr;
    logic [TIMER_W-1:0] w_tval_nx;
    logic [12:0]        w_is_nx;
    logic               w_badv_ex;
    logic [31:0]        w_rdata;
    logic               w_unused;

    // An exception in the same cycle suppresses any CSR write.
    assign w_wr   = bus.csr_we & ~bus.wb_ex;
    assign w_set  = bus.csr_wmask & bus.csr_wvalue;
    assign w_keep = ~bus.csr_wmask;

    assign w_crmd_wr = (w_wr && bus.csr_num == A_CRMD) ? (w_set[8:0] | (w_keep[8:0] & r_crmd)) : r_crmd;
    assign w_crmd_nx = {w_crmd_wr[8:3], bus.wb_ex ? 3'b000 : bus.ertn_flush ? r_prmd : w_crmd_wr[2:0]};

    // A TCFG write reloads the counter, so it never expires in that cycle.
    assign w_tcfg_we = w_wr && bus.csr_num == A_TCFG;
    assign w_tcfg_nx = w_tcfg_we ? (w_set | (w_keep & r_tcfg)) : r_tcfg;
    assign w_expire  = !w_tcfg_we && r_tcfg[0] && r_tval == TIMER_W'(1);
    assign w_tval_nx = w_tcfg_we ? {w_tcfg_nx[TIMER_W-1:2], 2'b00}
                     : !r_tcfg[0] ? r_tval
                     : r_tval != '0 ? r_tval - TIMER_W'(1)
                     : r_tcfg[1] ? {r_tcfg[TIMER_W-1:2], 2'b00}
                     : r_tval;

    assign w_ticlr = w_wr && bus.csr_num == 14'h44 && w_set[0];
    assign w_is_nx = {bus.ipi_int_in,
                      w_expire | (r_is[11] & ~w_ticlr),
                      1'b0,
                      bus.hw_int_in,
                      (w_wr && bus.csr_num == A_ESTAT) ? (w_set[1:0] | (w_keep[1:0] & r_is[1:0])) : r_is[1:0]};

    assign w_badv_ex = bus.wb_ex && (bus.wb_ecode == 6'h08 || bus.wb_ecode == 6'h09);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_crmd   <= 9'h008;
            r_prmd   <= '0;
            r_ecfg   <= '0;
            r_is     <= '0;
            r_ecode  <= '0;
            r_esub   <= '0;
            r_era    <= '0;
            r_badv   <= '0;
            r_eentry <= '0;
            r_tid    <= bus.coreid_in;
            r_tcfg   <= '0;
            r_tval   <= '0;
            for (int i = 0; i < 4; i++) r_save[i] <= '0;
        end else begin
            r_crmd   <= w_crmd_nx;
            r_prmd   <= bus.wb_ex ? r_crmd[2:0]
                      : (w_wr && bus.csr_num == A_PRMD) ? (w_set[2:0] | (w_keep[2:0] & r_prmd)) : r_prmd;
            r_ecfg   <= (w_wr && bus.csr_num == A_ECFG) ? ((w_set[12:0] | (w_keep[12:0] & r_ecfg)) & 13'h1bff) : r_ecfg;
            r_is     <= w_is_nx;
            r_ecode  <= bus.wb_ex ? bus.wb_ecode : r_ecode;
            r_esub   <= bus.wb_ex ? bus.wb_esubcode : r_esub;
            r_era    <= bus.wb_ex ? bus.wb_pc
                      : (w_wr && bus.csr_num == A_ERA) ? (w_set | (w_keep & r_era)) : r_era;
            r_badv   <= w_badv_ex ? bus.wb_vaddr
                      : (w_wr && bus.csr_num == A_BADV) ? (w_set | (w_keep & r_badv)) : r_badv;
            r_eentry <= (w_wr && bus.csr_num == A_EENTRY) ? (w_set[31:6] | (w_keep[31:6] & r_eentry)) : r_eentry;
            r_tid    <= (w_wr && bus.csr_num == A_TID) ? (w_set | (w_keep & r_tid)) : r_tid;
            r_tcfg   <= w_tcfg_nx;
            r_tval   <= w_tval_nx;
            for (int i = 0; i < 4; i++)
                if (w_wr && bus.csr_num == A_SAVE0 + 14'(i)) r_save[i] <= w_set | (w_keep & r_save[i]);
        end
    end

    always_comb begin
        case (bus.csr_num)
            A_CRMD:   w_rdata = {23'b0, r_crmd};
            A_PRMD:   w_rdata = {29'b0, r_prmd};
            A_ECFG:   w_rdata = {19'b0, r_ecfg};
            A_ESTAT:  w_rdata = {1'b0, r_esub, r_ecode, 3'b0, r_is};
            A_ERA:    w_rdata = r_era;
            A_BADV:   w_rdata = r_badv;
            A_EENTRY: w_rdata = {r_eentry, 6'b0};
            A_SAVE0:  w_rdata = r_save[0];
            A_SAVE1:  w_rdata = r_save[1];
            A_SAVE2:  w_rdata = r_save[2];
            A_SAVE3:  w_rdata = r_save[3];
            A_TID:    w_rdata = r_tid;
            A_TCFG:   w_rdata = r_tcfg;
            A_TVAL:   w_rdata = 32'(r_tval);
            default:  w_rdata = '0;
        endcase
    end

    assign bus.csr_rvalue = w_rdata;
    assign bus.has_int    = r_crmd[2] & |(r_ecfg & r_is);
    assign bus.ex_entry   = {r_eentry, 6'b0};
    assign bus.ertn_entry = r_era;
    assign w_unused       = bus.csr_re;
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed stimulus against an array-based CSR model checked every cycle, plus literal expectations.
module tb_csr_file;
    logic clk;
    logic resetn;
    int   n_chk = 0;
    int   n_err = 0;

    csr_file_if bus();
    csr_file #(.TIMER_W(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one 32-bit word per CSR index 0x00..0x44, updated by the architectural rules.
    logic [31:0] m [0:68];
    bit          m_valid = 1'b0;

    function automatic logic [31:0] wmask_of(input int n);
        case (n)
            'h00: return 32'h0000_01ff;
            'h01: return 32'h0000_0007;
            'h04: return 32'h0000_1bff;
            'h05: return 32'h0000_0003;
            'h0c: return 32'hffff_ffc0;
            'h06, 'h07, 'h30, 'h31, 'h32, 'h33, 'h40, 'h41: return 32'hffff_ffff;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [13:0] n);
        return (n <= 14'h44) ? m[int'(n)] : 32'h0;
    endfunction

    always @(posedge clk) begin
        logic [31:0] o [0:68];
        logic [31:0] eff;
        int n;
        bit ld, clr, fire;
        o = m;
        n = int'(bus.csr_num);
        ld = 1'b0;
        clr = 1'b0;
        fire = 1'b0;
        if (!resetn) begin
            foreach (m[i]) m[i] = 32'h0;
            m['h00] = 32'h8;
            m['h40] = bus.coreid_in;
        end else begin
            if (bus.wb_ex) begin
                m['h01] = {o['h01][31:3], o['h00][2:0]};
                m['h00] = {o['h00][31:3], 3'b000};
                m['h05][30:16] = {bus.wb_esubcode, bus.wb_ecode};
                m['h06] = bus.wb_pc;
                if (bus.wb_ecode == 6'h08 || bus.wb_ecode == 6'h09) m['h07] = bus.wb_vaddr;
            end else begin
                if (bus.csr_we && n <= 'h44) begin
                    eff = bus.csr_wmask & wmask_of(n);
                    m[n] = (o[n] & ~eff) | (bus.csr_wvalue & eff);
                end
                if (bus.csr_we && n == 'h41) begin
                    ld = 1'b1;
                    m['h42] = {m['h41][31:2], 2'b00};
                end
                clr = bus.csr_we && n == 'h44 && bus.csr_wmask[0] && bus.csr_wvalue[0];
                if (bus.ertn_flush) m['h00][2:0] = o['h01][2:0];
            end
            if (!ld && o['h41][0]) begin
                if (o['h42] != 0) begin
                    m['h42] = o['h42] - 1;
                    fire = (o['h42] == 1);
                end else if (o['h41][1]) m['h42] = {o['h41][31:2], 2'b00};
            end
            m['h05][11]  = fire | (o['h05][11] & !clr);
            m['h05][9:2] = bus.hw_int_in;
            m['h05][12]  = bus.ipi_int_in;
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_rvalue", bus.csr_rvalue, mread(bus.csr_num));
            chk("model_has_int", 32'(bus.has_int), 32'(m['h00][2] & |(m['h04][12:0] & m['h05][12:0])));
            chk("model_ex_entry", bus.ex_entry, m['h0c]);
            chk("model_ertn_entry", bus.ertn_entry, m['h06]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdm(input string nm, input logic [13:0] n, input logic [31:0] mask, input logic [31:0] exp);
        bus.csr_num = n;
        #1;
        chk(nm, bus.csr_rvalue & mask, exp);
    endtask

    task automatic rd(input string nm, input logic [13:0] n, input logic [31:0] exp);
        rdm(nm, n, 32'hffff_ffff, exp);
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] mk, input logic [31:0] v);
        bus.csr_we = 1'b1;
        bus.csr_num = n;
        bus.csr_wmask = mk;
        bus.csr_wvalue = v;
        tick();
        bus.csr_we = 1'b0;
    endtask

    task automatic ex(input logic [5:0] code, input logic [31:0] pc, input logic [31:0] va);
        bus.wb_ex = 1'b1;
        bus.wb_ecode = code;
        bus.wb_pc = pc;
        bus.wb_vaddr = va;
        tick();
        bus.wb_ex = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        bus.csr_re = 1'b0;
        bus.csr_num = '0;
        bus.csr_we = 1'b0;
        bus.csr_wmask = '0;
        bus.csr_wvalue = '0;
        bus.wb_ex = 1'b0;
        bus.wb_ecode = '0;
        bus.wb_esubcode = '0;
        bus.wb_pc = '0;
        bus.wb_vaddr = '0;
        bus.ertn_flush = 1'b0;
        bus.hw_int_in = '0;
        bus.ipi_int_in = 1'b0;
        bus.coreid_in = 32'h5;
        tick();
        tick();
        resetn = 1'b1;
        rd("reset_crmd", 14'h00, 32'h0000_0008);
        rd("reset_tid", 14'h40, 32'h0000_0005);
        rd("reset_save3", 14'h33, 32'h0);
        chk("reset_has_int", 32'(bus.has_int), 32'h0);

        wr(14'h00, 32'h7, 32'h7);
        rd("crmd_plv3_ie", 14'h00, 32'h0000_000f);
        ex(6'h09, 32'h1c00_0100, 32'h0000_1234);
        rdm("ex_crmd", 14'h00, 32'h7, 32'h0);
        rd("ex_prmd", 14'h01, 32'h7);
        rd("ex_era", 14'h06, 32'h1c00_0100);
        rd("ex_badv", 14'h07, 32'h0000_1234);
        rdm("ex_ecode", 14'h05, 32'h003f_0000, 32'h0009_0000);
        chk("ertn_entry", bus.ertn_entry, 32'h1c00_0100);
        bus.ertn_flush = 1'b1;
        tick();
        bus.ertn_flush = 1'b0;
        rdm("ertn_crmd", 14'h00, 32'h7, 32'h7);

        bus.ertn_flush = 1'b1;
        ex(6'h01, 32'h1c00_0200, 32'h0000_9999);
        bus.ertn_flush = 1'b0;
        rd("ex_wins_crmd", 14'h00, 32'h0000_0008);
        rd("ex_wins_prmd", 14'h01, 32'h7);
        rd("badv_kept", 14'h07, 32'h0000_1234);
        rd("ex_wins_era", 14'h06, 32'h1c00_0200);

        wr(14'h30, 32'hffff_ffff, 32'hffff_ffff);
        wr(14'h30, 32'h0000_ffff, 32'haaaa_5555);
        rd("save0_merge", 14'h30, 32'hffff_5555);
        bus.csr_we = 1'b1;
        bus.csr_wmask = 32'hffff_ffff;
        bus.csr_wvalue = 32'h0;
        ex(6'h00, 32'h1c00_0300, 32'h0);
        bus.csr_we = 1'b0;
        rd("save0_ex_drop", 14'h30, 32'hffff_5555);
        rd("ex_drop_era", 14'h06, 32'h1c00_0300);

        wr(14'h04, 32'hffff_ffff, 32'hffff_ffff);
        rd("ecfg_reserved", 14'h04, 32'h0000_1bff);
        wr(14'h02, 32'hffff_ffff, 32'hffff_ffff);
        rd("unimpl_read", 14'h02, 32'h0);
        wr(14'h42, 32'hffff_ffff, 32'h1234);
        rd("tval_ro", 14'h42, 32'h0);
        wr(14'h0c, 32'hffff_ffff, 32'h1234_5678);
        rd("eentry", 14'h0c, 32'h1234_5640);
        chk("ex_entry", bus.ex_entry, 32'h1234_5640);

        wr(14'h00, 32'h4, 32'h4);
        wr(14'h04, 32'hffff_ffff, 32'h800);
        wr(14'h41, 32'hffff_ffff, 32'hb);
        for (int v = 8; v >= 0; v--) begin
            rd("tval_count", 14'h42, 32'(v));
            if (v == 0) begin
                rdm("is11_expire", 14'h05, 32'h800, 32'h800);
                chk("timer_has_int", 32'(bus.has_int), 32'h1);
            end
            tick();
        end
        rd("tval_reload", 14'h42, 32'h8);
        wr(14'h44, 32'h1, 32'h1);
        rdm("ticlr_clear", 14'h05, 32'h800, 32'h0);
        chk("ticlr_has_int", 32'(bus.has_int), 32'h0);
        rd("ticlr_reads0", 14'h44, 32'h0);
        wr(14'h41, 32'hffff_ffff, 32'h0);

        wr(14'h41, 32'hffff_ffff, 32'h5);
        rd("oneshot_load", 14'h42, 32'h4);
        tick();
        tick();
        tick();
        rd("oneshot_one", 14'h42, 32'h1);
        wr(14'h44, 32'h1, 32'h1);
        rdm("expire_beats_clr", 14'h05, 32'h800, 32'h800);
        rd("oneshot_zero", 14'h42, 32'h0);
        tick();
        tick();
        tick();
        rd("oneshot_hold", 14'h42, 32'h0);
        wr(14'h44, 32'h1, 32'h1);
        tick();
        tick();
        rdm("oneshot_no_reint", 14'h05, 32'h800, 32'h0);

        wr(14'h04, 32'hffff_ffff, 32'h4);
        bus.hw_int_in = 8'h01;
        #1;
        chk("hw_latency", 32'(bus.has_int), 32'h0);
        tick();
        chk("hw_has_int", 32'(bus.has_int), 32'h1);
        wr(14'h00, 32'h4, 32'h0);
        chk("hw_ie_off", 32'(bus.has_int), 32'h0);
        bus.hw_int_in = 8'h00;
        bus.ipi_int_in = 1'b1;
        tick();
        rdm("ipi_is12", 14'h05, 32'h1000, 32'h1000);
        bus.ipi_int_in = 1'b0;

        bus.coreid_in = 32'h77;
        wr(14'h41, 32'hffff_ffff, 32'h103);
        tick();
        tick();
        resetn = 1'b0;
        bus.wb_ex = 1'b1;
        bus.wb_pc = 32'h1c00_0400;
        bus.ertn_flush = 1'b1;
        bus.csr_we = 1'b1;
        bus.csr_num = 14'h30;
        tick();
        resetn = 1'b1;
        bus.wb_ex = 1'b0;
        bus.ertn_flush = 1'b0;
        bus.csr_we = 1'b0;
        rd("rst_tval", 14'h42, 32'h0);
        rd("rst_tcfg", 14'h41, 32'h0);
        rd("rst_crmd", 14'h00, 32'h0000_0008);
        rd("rst_save0", 14'h30, 32'h0);
        rd("rst_tid", 14'h40, 32'h77);
        rd("rst_era", 14'h06, 32'h0);
        tick();
        tick();
        rd("rst_tval_idle", 14'h42, 32'h0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
